// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the sequential ALU and its iterative multiply/divide unit.
//   - 4-bit opcode encodings
//   - FSM state encoding
//   - default result for an illegal opcode (sliced to the ALU width by the user)
//   - helper that tells whether an opcode needs the iterative datapath
package alu_pkg;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpNor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpMul  = 4'b1000;
    localparam logic [3:0] OpDivu = 4'b1001;

    // Wide enough for the largest legal WIDTH (64).
    localparam logic [63:0] IllegalResult = 64'h0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OpMul) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned multiply (shift-add, low WIDTH bits kept)
// and unsigned divide (restoring, MSB first).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             load operands and begin; the first iteration runs on the next edge
//   div_i               1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i            multiplicand/multiplier or dividend/divisor
//   done_o              high during the cycle whose edge performs the final iteration
//   res_o, rem_o        product/quotient and remainder as they will be after that edge
// Exactly WIDTH iterations are run. Divide by zero naturally yields quotient all ones and
// remainder equal to the dividend, because every trial subtraction of zero succeeds.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    // acc: running product (mul) or partial remainder (div)
    logic [WIDTH-1:0] acc_q, acc_d;
    // opa: shifting multiplicand (mul) or dividend shifting out / quotient shifting in (div)
    logic [WIDTH-1:0] opa_q, opa_d;
    // opb: shifting multiplier (mul) or fixed divisor (div)
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic             run_q, run_d;

    logic             last;
    logic [WIDTH:0]   trial;

    assign last  = run_q && (cnt_q == CntW'(WIDTH - 1));
    // Partial remainder with the next dividend bit shifted in; one extra bit so it cannot
    // overflow before the compare.
    assign trial = {acc_q, opa_q[WIDTH-1]};

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        div_d = div_q;
        run_d = run_q;
        if (start_i) begin
            cnt_d = '0;
            acc_d = '0;
            opa_d = a_i;
            opb_d = b_i;
            div_d = div_i;
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
                run_d = 1'b0;
            end
            if (div_q) begin
                if (trial >= {1'b0, opb_q}) begin
                    // Difference is below the divisor, so it fits in WIDTH bits.
                    acc_d = trial[WIDTH-1:0] - opb_q;
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = trial[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opa_q;
                end
                opa_d = {opa_q[WIDTH-2:0], 1'b0};
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            div_q <= div_d;
            run_q <= run_d;
        end
    end

    // Next-state values so the caller can register the result on the final iteration edge.
    assign done_o = last;
    assign res_o  = div_q ? opa_d : acc_d;
    assign rem_o  = div_q ? acc_d : '0;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake on both sides.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid, in_ready          request handshake (in_ready only in IDLE)
//   op, a, b                    opcode and operands, used at accept
//   out_valid, out_ready        result handshake (result held in DONE until taken)
//   result, rem                 primary result, remainder (DIVU only, else 0)
//   zout, nout, vout, err       zero, negative, signed overflow, illegal op / divide by zero
// Build option: define ALU_SEQ_MULDIV_EN to include the iterative MUL/DIVU datapath and
// the BUSY state. Without it, opcodes 1000/1001 are treated as illegal with 1-cycle latency.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             zout,
    output logic             nout,
    output logic             vout,
    output logic             err
);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             zout_q, zout_d;
    logic             nout_q, nout_d;
    logic             vout_q, vout_d;
    logic             err_q, err_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v, alu_err;

    assign sum  = a + b;
    assign diff = a + ~b + WIDTH'(1);
    assign slt  = $signed(a) < $signed(b);

    always_comb begin
        alu_res = IllegalResult[WIDTH-1:0];
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op)
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpAdd: begin
                alu_res = sum;
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpNor: alu_res = ~(a | b);
            OpSub: begin
                alu_res = diff;
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpSlt: alu_res = {{(WIDTH - 1){1'b0}}, slt};
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH-1:0] md_rem;
    // Divide-by-zero is known at accept; remember it to raise err when the result lands.
    logic             divz_q, divz_d;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk_i   (clk),
        .rst_i   (reset),
        .start_i (md_start),
        .div_i   (op == OpDivu),
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done),
        .res_o   (md_res),
        .rem_o   (md_rem)
    );
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rem_d       = rem_q;
        zout_d      = zout_q;
        nout_d      = nout_q;
        vout_d      = vout_q;
        err_d       = err_q;
`ifdef ALU_SEQ_MULDIV_EN
        md_start    = 1'b0;
        divz_d      = divz_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_muldiv(op)) begin
                        md_start = 1'b1;
                        divz_d   = (op == OpDivu) && (b == '0);
                        state_d  = StBusy;
                    end else
`endif
                    begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        rem_d       = '0;
                        zout_d      = (alu_res == '0);
                        nout_d      = alu_res[WIDTH-1];
                        vout_d      = alu_v;
                        err_d       = alu_err;
                    end
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            StBusy: begin
                if (md_done) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    result_d    = md_res;
                    rem_d       = md_rem;
                    zout_d      = (md_res == '0);
                    nout_d      = md_res[WIDTH-1];
                    vout_d      = 1'b0;
                    err_d       = divz_q;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rem_q       <= '0;
            zout_q      <= 1'b0;
            nout_q      <= 1'b0;
            vout_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            divz_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rem_q       <= rem_d;
            zout_q      <= zout_d;
            nout_q      <= nout_d;
            vout_q      <= vout_d;
            err_q       <= err_d;
`ifdef ALU_SEQ_MULDIV_EN
            divz_q      <= divz_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rem       = rem_q;
    assign zout      = zout_q;
    assign nout      = nout_q;
    assign vout      = vout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=32 instance and a WIDTH=8 instance share clock/reset.
// MUL/DIVU expectations follow whether ALU_SEQ_MULDIV_EN is defined for this build.
module tb_alu_seq;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpNor  = 4'b0011;
    localparam logic [3:0] OpBad  = 4'b0100;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpMul  = 4'b1000;
    localparam logic [3:0] OpDivu = 4'b1001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] a, b, result, rem;
    logic        zout, nout, vout, err;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, result8, rem8;
    logic        zout8, nout8, vout8, err8;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready), .op (op),
        .a (a), .b (b), .out_valid (out_valid), .out_ready (out_ready), .result (result),
        .rem (rem), .zout (zout), .nout (nout), .vout (vout), .err (err)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk (clk), .reset (reset), .in_valid (in_valid8), .in_ready (in_ready8), .op (op8),
        .a (a8), .b (b8), .out_valid (out_valid8), .out_ready (out_ready8), .result (result8),
        .rem (rem8), .zout (zout8), .nout (nout8), .vout (vout8), .err (err8)
    );

    // Starts at a negedge; returns at the negedge where out_valid is first seen (or timeout).
    // lat = 1 means out_valid visible right after the accept edge.
    task automatic run32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output bit rdy_seen);
        int guard = 0;
        rdy_seen = 1'b0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            $display("FAIL in_ready_wait got=0 exp=1");
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; they must not matter.
        in_valid = 1'b0; op = OpAdd; a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume32;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, result, rem, zout, nout, vout, err} !== 70'h0)
            $display("FAIL reset32_outs got=%h exp=0",
                     {out_valid, result, rem, zout, nout, vout, err});
        else passed++;
        total++;
        if ({out_valid8, result8, rem8, zout8, nout8, vout8, err8} !== 22'h0)
            $display("FAIL reset8_outs got=%h exp=0",
                     {out_valid8, result8, rem8, zout8, nout8, vout8, err8});
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, in_ready8, out_valid} !== 3'b110)
            $display("FAIL reset_ready got=%b exp=110", {in_ready, in_ready8, out_valid});
        else passed++;
    endtask

    task automatic test_add_overflow;
        int lat;
        bit rs;
        run32(OpAdd, 32'h7FFF_FFFF, 32'h1, lat, rs);
        total++;
        if (lat !== 1) $display("FAIL add_latency got=%0d exp=1", lat); else passed++;
        total++;
        if (result !== 32'h8000_0000) $display("FAIL add_result got=%h exp=80000000", result);
        else passed++;
        total++;
        if ({zout, nout, vout, err} !== 4'b0110)
            $display("FAIL add_flags got=%b exp=0110", {zout, nout, vout, err});
        else passed++;
        consume32();
    endtask

    task automatic test_sub_slt;
        int lat;
        bit rs;
        run32(OpSub, 32'd5, 32'd5, lat, rs);
        total++;
        if ({result, zout, nout, vout, err} !== {32'h0, 4'b1000})
            $display("FAIL sub_zero got=%h/%b exp=0/1000", result, {zout, nout, vout, err});
        else passed++;
        consume32();
        run32(OpSlt, 32'hFFFF_FFFF, 32'd1, lat, rs);
        total++;
        if ({result, zout, nout, vout, err, lat} !== {32'h1, 4'b0000, 32'd1})
            $display("FAIL slt_neg got=%h/%b/%0d exp=1/0000/1",
                     result, {zout, nout, vout, err}, lat);
        else passed++;
        consume32();
    endtask

    task automatic test_logic;
        int lat;
        bit rs;
        run32(OpAnd, 32'hFF00_FF00, 32'h0FF0_0FF0, lat, rs);
        total++;
        if ({result, zout, nout, vout, err} !== {32'h0F00_0F00, 4'b0000})
            $display("FAIL and got=%h/%b exp=0f000f00/0000", result, {zout, nout, vout, err});
        else passed++;
        consume32();
        run32(OpNor, 32'h0F0F_0000, 32'h0000_00FF, lat, rs);
        total++;
        if ({result, zout, nout, vout, err} !== {32'hF0F0_FF00, 4'b0100})
            $display("FAIL nor got=%h/%b exp=f0f0ff00/0100", result, {zout, nout, vout, err});
        else passed++;
        consume32();
        run32(OpSub, 32'h8000_0000, 32'h1, lat, rs);
        total++;
        if ({result, zout, nout, vout, err} !== {32'h7FFF_FFFF, 4'b0010})
            $display("FAIL sub_ovf got=%h/%b exp=7fffffff/0010", result, {zout, nout, vout, err});
        else passed++;
        consume32();
        run32(OpBad, 32'h1234, 32'h5678, lat, rs);
        total++;
        if ({result, rem, zout, nout, vout, err, lat} !== {64'h0, 4'b1001, 32'd1})
            $display("FAIL illegal got=%h/%h/%b/%0d exp=0/0/1001/1",
                     result, rem, {zout, nout, vout, err}, lat);
        else passed++;
        consume32();
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic test_muldiv;
        int lat;
        bit rs;
        run32(OpMul, 32'h0001_0000, 32'h0001_0003, lat, rs);
        total++;
        if (lat !== 33) $display("FAIL mul_latency got=%0d exp=33", lat); else passed++;
        total++;
        if (rs !== 1'b0) $display("FAIL mul_in_ready got=%b exp=0", rs); else passed++;
        total++;
        if ({result, rem, zout, nout, vout, err} !== {32'h0003_0000, 32'h0, 4'b0000})
            $display("FAIL mul_result got=%h/%h/%b exp=00030000/0/0000",
                     result, rem, {zout, nout, vout, err});
        else passed++;
        consume32();
        run32(OpDivu, 32'd100, 32'd7, lat, rs);
        total++;
        if ({result, rem, err, lat} !== {32'd14, 32'd2, 1'b0, 32'd33})
            $display("FAIL divu got=%0d/%0d/%b/%0d exp=14/2/0/33", result, rem, err, lat);
        else passed++;
        consume32();
        run32(OpDivu, 32'd9, 32'd0, lat, rs);
        total++;
        if ({result, rem, zout, nout, vout, err, lat} !==
            {32'hFFFF_FFFF, 32'd9, 4'b0101, 32'd33})
            $display("FAIL divu_zero got=%h/%h/%b/%0d exp=ffffffff/9/0101/33",
                     result, rem, {zout, nout, vout, err}, lat);
        else passed++;
        consume32();
    endtask
`else
    task automatic test_muldiv;
        int lat;
        bit rs;
        run32(OpMul, 32'h0001_0000, 32'h0001_0003, lat, rs);
        total++;
        if ({result, rem, zout, nout, vout, err, lat} !== {64'h0, 4'b1001, 32'd1})
            $display("FAIL mul_disabled got=%h/%h/%b/%0d exp=0/0/1001/1",
                     result, rem, {zout, nout, vout, err}, lat);
        else passed++;
        consume32();
    endtask
`endif

    task automatic test_hold;
        int lat;
        bit rs;
        run32(OpOr, 32'hF0F0_0000, 32'h0000_0F0F, lat, rs);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); op = OpAdd; a = i; b = 32'd1;
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, result, rem, zout, nout, vout, err} !==
                {2'b10, 32'hF0F0_0F0F, 32'h0, 4'b0100})
                $display("FAIL hold_cycle%0d got=%b/%h/%b exp=10/f0f00f0f/0100", i,
                         {out_valid, in_ready}, result, {zout, nout, vout, err});
            else passed++;
        end
        in_valid = 1'b0;
        consume32();
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready});
        else passed++;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL hold_no_stray got=%b exp=01", {out_valid, in_ready});
        else passed++;
    endtask

    task automatic test_reset_done;
        int lat;
        bit rs;
        run32(OpAdd, 32'h7FFF_FFFF, 32'h1, lat, rs);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid, result, rem, zout, nout, vout, err} !== 70'h0)
            $display("FAIL reset_done got=%h exp=0",
                     {out_valid, result, rem, zout, nout, vout, err});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_done_after got=%b exp=01", {out_valid, in_ready});
        else passed++;
    endtask

    // Reset while an operation is in flight (BUSY when the iterative path exists, else DONE
    // of an illegal op) must clear everything and never produce a result for it.
    task automatic test_reset_busy;
        int seen = 0;
`ifdef ALU_SEQ_MULDIV_EN
        int lat;
        bit rs;
        // Leave a nonzero result/rem/err behind from the previous op.
        run32(OpDivu, 32'd9, 32'd0, lat, rs);
        consume32();
        op = OpMul; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
`else
        op = OpBad; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`endif
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid, result, rem, zout, nout, vout, err} !== 70'h0)
            $display("FAIL reset_inflight got=%h exp=0",
                     {out_valid, result, rem, zout, nout, vout, err});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL reset_no_valid got=%0d exp=0", seen); else passed++;
    endtask

    task automatic test_width8;
        int lat;
        run8(OpNor, 8'h0F, 8'h30, lat);
        total++;
        if ({result8, zout8, nout8, vout8, err8, lat} !== {8'hC0, 4'b0100, 32'd1})
            $display("FAIL w8_nor got=%h/%b/%0d exp=c0/0100/1",
                     result8, {zout8, nout8, vout8, err8}, lat);
        else passed++;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        run8(OpMul, 8'h0F, 8'h11, lat);
`ifdef ALU_SEQ_MULDIV_EN
        total++;
        if ({result8, zout8, nout8, vout8, err8, lat} !== {8'hFF, 4'b0100, 32'd9})
            $display("FAIL w8_mul got=%h/%b/%0d exp=ff/0100/9",
                     result8, {zout8, nout8, vout8, err8}, lat);
        else passed++;
`else
        total++;
        if ({result8, rem8, zout8, nout8, vout8, err8, lat} !== {16'h0, 4'b1001, 32'd1})
            $display("FAIL w8_mul_illegal got=%h/%h/%b/%0d exp=0/0/1001/1",
                     result8, rem8, {zout8, nout8, vout8, err8}, lat);
        else passed++;
`endif
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_logic();
        test_muldiv();
        test_hold();
        test_reset_done();
        test_reset_busy();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  4  operation select (Function table).
REQ-007 a, b  input  WIDTH each  operands, sampled on accept.
REQ-008 out_valid  output  1  result outputs valid.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 result  output  WIDTH  primary result.
REQ-011 rem  output  WIDTH  remainder for DIVU, else zero.
REQ-012 zout, nout, vout, err  output  1 each  zero, negative, signed-overflow, illegal-op or divide-by-zero.

Function
REQ-013 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 NOR, 0110 SUB (a+~b+1), 0111 SLT (signed, result 1/0), 1000 MUL (unsigned, low WIDTH bits), 1001 DIVU (unsigned quotient, remainder on rem); every other code is illegal.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-015 Accept = in_valid & in_ready at a rising edge; a, b, op are registered on accept, and later input changes have no effect.
REQ-016 Single-cycle ops (AND/OR/ADD/NOR/SUB/SLT/illegal): IDLE->DONE on accept; out_valid asserted exactly 1 cycle after accept.
REQ-017 MUL/DIVU: IDLE->BUSY on accept; iterate 1 bit/cycle for exactly WIDTH cycles; BUSY->DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-018 MUL is shift-add; DIVU is restoring, MSB first.
REQ-019 DONE holds result, rem, flags stable while out_ready=0; DONE->IDLE on out_ready=1; no accept in the same cycle as the DONE->IDLE transition.
REQ-020 zout = (result==0); nout = result[WIDTH-1]; all flags are registered with result.
REQ-021 vout = signed overflow for ADD (operand signs equal, result sign differs) and SUB (operand signs differ, result sign differs from a); vout=0 for all other ops.
REQ-022 DIVU with b=0: result all ones, rem=a, err=1, latency unchanged (WIDTH+1).
REQ-023 Illegal op: result=0, rem=0, err=1, zout=1.
REQ-024 out_ready while not DONE is ignored; in_valid while not IDLE is ignored and has no side effect.

Reset
REQ-025 reset asynchronously forces state IDLE, iteration counter 0, and result, rem, out_valid, zout, nout, vout, err all to 0; in_ready=1 from the first clock after deassertion.
REQ-026 reset during BUSY or DONE discards the operation; no out_valid is produced for it.

Configuration
REQ-027 Macro ALU_SEQ_MULDIV_EN: defined -> MUL/DIVU are implemented as in REQ-017/018/022. Undefined -> no iterative datapath and no BUSY state are synthesised; 1000/1001 are illegal per REQ-023 with 1-cycle latency.

Structure
REQ-028 Shared package alu_pkg holds the opcode constants, FSM state encoding and the illegal-op default result.
REQ-029 Iterative MUL/DIVU lives in sub-module alu_muldiv_iter (start, op-select, operands in; done, product/quotient, remainder out), instantiated only under ALU_SEQ_MULDIV_EN.

Verification
REQ-030 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> out_valid next cycle, result 0x80000000, vout=1, nout=1, zout=0.
REQ-031 SUB a=5 b=5, then SLT a=0xFFFFFFFF b=1 -> result 0 zout=1 vout=0; then result 1.
REQ-032 MUL a=0x10000 b=0x10003 -> out_valid exactly 33 cycles after accept, result 0x00030000; in_ready=0 throughout.
REQ-033 DIVU a=100 b=7 -> result 14, rem 2; DIVU a=9 b=0 -> result 0xFFFFFFFF, rem 9, err=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_valid pulses ignored; assert reset mid-BUSY -> all outputs 0 immediately, no out_valid afterwards.
REQ-035 Rebuild with WIDTH=8 and ALU_SEQ_MULDIV_EN undefined: op 1000 -> err=1, result 0, 1-cycle latency; NOR a=0x0F b=0x30 -> 0xC0.
